// File: rtl/mmio_pkg.sv
// Shared register map and defaults for the memory-mapped IO responder.
package mmio_pkg;
  localparam int IO_LSB_DEFAULT = 9;

  typedef enum logic [1:0] {
    REG_LED = 2'd0,
    REG_SW  = 2'd1,
    REG_BTN = 2'd2,
    REG_HEX = 2'd3
  } reg_e;
endpackage

// File: rtl/mmio_peripheral_if.sv
// CPU-side load/store port shared with memory; the peripheral is the slave.
interface mmio_peripheral_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  write;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output addr, wdata, write, input rdata);
  modport slave  (input addr, wdata, write, output rdata);
endinterface

// File: rtl/hex_to_7seg.sv
// Nibble to active-high segment pattern {g,f,e,d,c,b,a}.
module hex_to_7seg (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h00;
    unique case (nib_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end
endmodule

// File: rtl/mmio_peripheral.sv
// IO-window responder: LED/HEX registers, debounced switches, sticky buttons,
// and a 4-digit multiplexed hex display.
module mmio_peripheral
  import mmio_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int IO_LSB          = IO_LSB_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SCAN_CYCLES     = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  mmio_peripheral_if.slave bus,
  input  logic [9:0] sw_in,
  input  logic [3:0] btn_in,
  output logic [9:0] led_out,
  output logic [6:0] seg_n,
  output logic [3:0] an_n
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int SCW = $clog2(SCAN_CYCLES);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCW-1:0] SC_MAX = SCW'(SCAN_CYCLES - 1);

  logic io_sel, wr, rd;
  reg_e rsel;
  assign io_sel = |bus.addr[ADDR_WIDTH-1:IO_LSB];
  assign rsel   = reg_e'(bus.addr[1:0]);
  assign wr     = io_sel & bus.write;
  assign rd     = io_sel & ~bus.write;

  // Inputs packed as {btn[3:0], sw[9:0]} through sync, sample and debounce.
  logic [13:0] sync1_q, sync2_q, samp_q, deb_q, deb_d, eq;
  logic [DBW-1:0] dbc_q;
  logic tick;
  assign tick = (dbc_q == DB_MAX);
  assign eq   = ~(sync2_q ^ samp_q);

  always_comb begin
    deb_d = deb_q;
    if (tick) deb_d = (eq & sync2_q) | (~eq & deb_q);
  end

  logic [3:0] sticky_q, sticky_d, rise, clr;
  assign rise = deb_d[13:10] & ~deb_q[13:10];
  assign clr  = (rd && rsel == REG_BTN) ? sticky_q : 4'h0;
  // A rising edge on the clearing edge re-sets the bit.
  assign sticky_d = (sticky_q & ~clr) | rise;

  logic [9:0]            led_q;
  logic [15:0]           hex_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (rsel)
        REG_LED: rdata_d[9:0]  = led_q;
        REG_SW:  rdata_d[9:0]  = deb_q[9:0];
        REG_BTN: rdata_d[3:0]  = sticky_q;
        REG_HEX: rdata_d[15:0] = hex_q;
        default: rdata_d = '0;
      endcase
    end
  end

  logic [SCW-1:0] scan_q;
  logic [1:0]     idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      samp_q   <= '0;
      deb_q    <= '0;
      dbc_q    <= '0;
      sticky_q <= '0;
      led_q    <= '0;
      hex_q    <= '0;
      rdata_q  <= '0;
      scan_q   <= '0;
      idx_q    <= '0;
    end else begin
      sync1_q  <= {btn_in, sw_in};
      sync2_q  <= sync1_q;
      dbc_q    <= tick ? '0 : dbc_q + 1'b1;
      if (tick) samp_q <= sync2_q;
      deb_q    <= deb_d;
      sticky_q <= sticky_d;
      rdata_q  <= rdata_d;
      if (wr && rsel == REG_LED) led_q <= bus.wdata[9:0];
      if (wr && rsel == REG_HEX) hex_q <= bus.wdata[15:0];
      if (scan_q == SC_MAX) begin
        scan_q <= '0;
        idx_q  <= idx_q + 2'd1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
    end
  end

  logic [6:0] seg;
  hex_to_7seg u_hex (
    .nib_i (hex_q[4*idx_q +: 4]),
    .seg_o (seg)
  );

  assign bus.rdata = rdata_q;
  assign led_out   = led_q;
  assign seg_n     = ~seg;
  assign an_n      = ~(4'b0001 << idx_q);
endmodule
